// File: rtl/tsen_multi_ctrl.sv
// tsen_multi_ctrl: round-robin multi-channel oscillator-count temperature sensor controller
module tsen_multi_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [11:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o,
  output logic              error_o,
  input  logic [NUM_CH-1:0] osc_i,
  output logic              irq_o
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [2:0] {IDLE, ARM, COUNT, STORE, NEXT} state_e;
  state_e state_q, state_d;
  logic en_q, en_d, start_q, start_d, cont_q, cont_d, irq_en_q, irq_en_d;
  logic [WIN_W-1:0] window_q, window_d, win_cnt_q, win_cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d, done_q, done_d, alarm_q, alarm_d, prev_q, prev_d, pulse;
  logic [CNT_W-1:0] thresh_q, thresh_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] result_q, result_d;
  logic [CW-1:0] ch_q, ch_d, lo_ch, nx_ch;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [31:0] rdata_q, rdata_d, rd_val, bm, wv, ctrl_m, win_m, mask_m, thr_m;
  logic error_q, error_d, mapped, busy, nx_found, unused_ok;
  logic [9:0] widx;
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction
  assign widx = addr_i[11:2];
  assign busy = state_q != IDLE;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], osc_i};
  assign prev_d = sync_q[SYNC_STAGES-1];
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign unused_ok = ^{addr_i[1:0], ctrl_m, win_m, mask_m, thr_m, wv};
  assign rdata_o = rdata_q;
  assign error_o = error_q;
  assign irq_o = (|(done_q & mask_q) & irq_en_q) | |alarm_q;
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (widx)
      10'h000: rd_val[3:0] = {irq_en_q, cont_q, 1'b0, en_q};
      10'h001: rd_val[WIN_W-1:0] = window_q;
      10'h002: rd_val[NUM_CH-1:0] = mask_q;
      10'h003: rd_val = {20'd0, 4'(ch_q), 7'd0, busy};
      10'h004: rd_val[NUM_CH-1:0] = done_q;
      10'h005: rd_val[NUM_CH-1:0] = alarm_q;
      10'h006: rd_val[CNT_W-1:0] = thresh_q;
      default: begin
        mapped = 1'b0;
        for (int n = 0; n < NUM_CH; n++)
          if (widx == 10'(16 + n)) begin
            rd_val[CNT_W-1:0] = result_q[n];
            mapped = 1'b1;
          end
      end
    endcase
    rdata_d = re_i && mapped ? rd_val : '0;
    error_d = (re_i | we_i) & ~mapped;
  end
  always_comb begin
    lo_ch = '0;
    nx_ch = '0;
    nx_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) lo_ch = CW'(i);
      if (mask_q[i] && i > int'(ch_q)) begin
        nx_ch = CW'(i);
        nx_found = 1'b1;
      end
    end
  end
  always_comb begin
    bm = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    wv = wdata_i & bm;
    ctrl_m = merge({28'd0, irq_en_q, cont_q, 1'b0, en_q}, wdata_i, bm);
    win_m = merge(32'(window_q), wdata_i, bm);
    mask_m = merge(32'(mask_q), wdata_i, bm);
    thr_m = merge(32'(thresh_q), wdata_i, bm);
    {irq_en_d, cont_d, start_d, en_d} = (we_i && widx == 10'h0) ? ctrl_m[3:0] : {irq_en_q, cont_q, 1'b0, en_q};
    window_d = (we_i && widx == 10'h1) ? (win_m[WIN_W-1:0] == '0 ? WIN_W'(1) : win_m[WIN_W-1:0]) : window_q;
    mask_d = (we_i && widx == 10'h2) ? mask_m[NUM_CH-1:0] : mask_q;
    done_d = (we_i && widx == 10'h4) ? done_q & ~wv[NUM_CH-1:0] : done_q;
    alarm_d = (we_i && widx == 10'h5) ? alarm_q & ~wv[NUM_CH-1:0] : alarm_q;
    thresh_d = (we_i && widx == 10'h6) ? thr_m[CNT_W-1:0] : thresh_q;
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    win_cnt_d = win_cnt_q;
    result_d = result_q;
    // Dropping en abandons the in-flight channel without storing anything.
    if (busy && !en_q) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start_q && en_q && mask_q != '0) begin
          state_d = ARM;
          ch_d = lo_ch;
        end
        ARM: begin
          cnt_d = '0;
          win_cnt_d = window_q;
          state_d = COUNT;
        end
        COUNT: begin
          cnt_d = (pulse[ch_q] && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
          win_cnt_d = win_cnt_q - 1'b1;
          state_d = win_cnt_q == WIN_W'(1) ? STORE : COUNT;
        end
        STORE: begin
          result_d[ch_q] = cnt_q;
          done_d[ch_q] = 1'b1;
          alarm_d[ch_q] = alarm_d[ch_q] | (cnt_q > thresh_q);
          state_d = NEXT;
        end
        NEXT: begin
          state_d = (nx_found || (cont_q && mask_q != '0)) ? ARM : IDLE;
          ch_d = nx_found ? nx_ch : lo_ch;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      start_q <= 1'b0;
      cont_q <= 1'b0;
      irq_en_q <= 1'b0;
      window_q <= WIN_W'(1);
      win_cnt_q <= '0;
      mask_q <= '0;
      done_q <= '0;
      alarm_q <= '0;
      prev_q <= '0;
      thresh_q <= '1;
      cnt_q <= '0;
      result_q <= '0;
      ch_q <= '0;
      sync_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      start_q <= start_d;
      cont_q <= cont_d;
      irq_en_q <= irq_en_d;
      window_q <= window_d;
      win_cnt_q <= win_cnt_d;
      mask_q <= mask_d;
      done_q <= done_d;
      alarm_q <= alarm_d;
      prev_q <= prev_d;
      thresh_q <= thresh_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      ch_q <= ch_d;
      sync_q <= sync_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_tsen_multi_ctrl.sv
// tb_tsen_multi_ctrl: directed and randomized register-level checks against a timing/count model
module tb_tsen_multi_ctrl;
  localparam int NCH = 4;
  logic clk = 1'b0, rst = 1'b1, re = 1'b0, we = 1'b0, error, irq;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0, rdata, d;
  logic [3:0] be = '0;
  logic [NCH-1:0] osc = '0;
  logic e;
  int per[NCH], ph[NCH];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tsen_multi_ctrl dut (
    .clk_i(clk), .rst_i(rst), .re_i(re), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdata), .error_o(error), .osc_i(osc), .irq_o(irq)
  );
  // Square-wave oscillators, period per[i] clk cycles, 0 = held low.
  always @(negedge clk)
    for (int i = 0; i < NCH; i++)
      if (per[i] == 0) begin
        osc[i] = 1'b0;
        ph[i] = 0;
      end else begin
        osc[i] = ph[i] < per[i] / 2;
        ph[i] = (ph[i] + 1) % per[i];
      end
  task automatic wr(input logic [11:0] a, input logic [31:0] v, input logic [3:0] b = 4'hF);
    addr = a; wdata = v; be = b; we = 1'b1;
    @(negedge clk);
    we = 1'b0; be = '0;
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] v, output logic er);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0; v = rdata; er = error;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd(a, d, e);
    chk(tag, d, exp);
  endtask
  initial begin
    logic [11:0] ra[11] = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h10, 12'h14, 12'h18, 12'h40, 12'h44, 12'h48, 12'h4C};
    logic [31:0] rx[11] = '{0, 1, 0, 0, 0, 0, 32'hFFFF, 0, 0, 0, 0};
    int n, w, thr, lo, hi;
    int first[NCH];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("irq_reset", 32'(irq), 0);
    for (int i = 0; i < 11; i++) begin
      rd(ra[i], d, e);
      chk($sformatf("reset_reg_%h", ra[i]), d, rx[i]);
      chk($sformatf("reset_err_%h", ra[i]), 32'(e), 0);
    end
    rd(12'h30, d, e);
    chk("unmapped_err", 32'(e), 1);
    chk("unmapped_data", d, 0);
    rd(12'h50, d, e);
    chk("result4_err", 32'(e), 1);
    wr(12'h04, 0);
    chk_rd("window_zero", 12'h04, 1);
    addr = 12'h04; wdata = 77; be = 4'hF; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("rw_same_cycle", rdata, 1);
    chk_rd("window_after_rw", 12'h04, 77);
    wr(12'h18, 32'h1234, 4'h1);
    chk_rd("thresh_be", 12'h18, 32'hFF34);
    wr(12'h18, 32'hFFFF);
    // Single channel: start to DONE is WINDOW+3 cycles, count ~ WINDOW/period.
    per[1] = 10;
    wr(12'h04, 690);
    wr(12'h08, 2);
    wr(12'h00, 32'hB);
    n = 0;
    while (irq !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 693);
    chk_rd("done_ch1", 12'h10, 2);
    rd(12'h44, d, e);
    chk("result1_range", 32'(d >= 68 && d <= 70), 1);
    repeat (2) @(negedge clk);
    rd(12'h0C, d, e);
    chk("busy_after_single", {31'd0, d[0]}, 0);
    chk_rd("no_alarm", 12'h14, 0);
    wr(12'h10, 32'hF);
    wr(12'h00, 0);
    chk("irq_cleared", 32'(irq), 0);
    // Full scan: iteration 0 is the fixed case, iteration 1 randomized.
    for (int it = 0; it < 2; it++) begin
      w = it == 0 ? 100 : int'($urandom_range(30, 80));
      thr = it == 0 ? 32'hFFFF : int'($urandom_range(4, 12));
      for (int i = 0; i < NCH; i++) begin
        per[i] = it == 0 ? 10 : int'($urandom_range(3, 9));
        first[i] = -1;
      end
      wr(12'h04, 32'(w));
      wr(12'h18, 32'(thr));
      wr(12'h08, 32'hF);
      wr(12'h10, 32'hF);
      wr(12'h14, 32'hF);
      wr(12'h00, 3);
      for (int k = 1; k <= 4 * (w + 3) + 10; k++) begin
        rd(12'h10, d, e);
        for (int i = 0; i < NCH; i++)
          if (d[i] && first[i] < 0) first[i] = k - 1;
      end
      for (int i = 0; i < NCH; i++) chk($sformatf("done_time_%0d_ch%0d", it, i), 32'(first[i]), 32'((i + 1) * (w + 3)));
      rd(12'h0C, d, e);
      chk("busy_after_scan", {31'd0, d[0]}, 0);
      rd(12'h14, wdata, e);
      for (int i = 0; i < NCH; i++) begin
        lo = w / per[i] - 1;
        hi = w / per[i] + 1;
        rd(12'(12'h40 + 4 * i), d, e);
        chk($sformatf("result_range_%0d_ch%0d", it, i), 32'(int'(d) >= lo && int'(d) <= hi), 1);
        if (lo > thr) chk($sformatf("alarm_%0d_ch%0d", it, i), 32'(wdata[i]), 1);
        if (hi <= thr) chk($sformatf("alarm_%0d_ch%0d", it, i), 32'(wdata[i]), 0);
      end
    end
    // ALARM W1C landing on the STORE edge: the set must win.
    per[1] = 10;
    wr(12'h18, 10);
    wr(12'h04, 200);
    wr(12'h08, 2);
    wr(12'h10, 32'hF);
    wr(12'h14, 32'hF);
    wr(12'h00, 3);
    repeat (202) @(negedge clk);
    wr(12'h14, 2);
    chk_rd("alarm_set_wins", 12'h14, 2);
    chk("irq_alarm", 32'(irq), 1);
    wr(12'h14, 2);
    chk_rd("alarm_w1c", 12'h14, 0);
    chk("irq_alarm_clr", 32'(irq), 0);
    // Continuous scan over channels 0 and 2 wraps back to channel 0.
    per[0] = 5; per[2] = 5;
    wr(12'h04, 20);
    wr(12'h08, 5);
    wr(12'h10, 32'hF);
    wr(12'h00, 7);
    repeat (50) @(negedge clk);
    wr(12'h10, 5);
    repeat (9) @(negedge clk);
    chk_rd("cont_before_wrap", 12'h10, 0);
    repeat (11) @(negedge clk);
    chk_rd("cont_wrap_ch0", 12'h10, 1);
    chk_rd("cont_status", 12'h0C, 32'h201);
    wr(12'h00, 0);
    @(negedge clk);
    rd(12'h0C, d, e);
    chk("busy_after_en_clr", {31'd0, d[0]}, 0);
    chk_rd("done_after_en_clr", 12'h10, 1);
    // Abort mid-COUNT on a channel whose stored result is exactly known.
    per[3] = 0;
    wr(12'h08, 8);
    wr(12'h04, 30);
    wr(12'h10, 32'hF);
    wr(12'h00, 3);
    repeat (40) @(negedge clk);
    chk_rd("result3_silent", 12'h4C, 0);
    chk_rd("done3_silent", 12'h10, 8);
    per[3] = 3;
    wr(12'h10, 32'hF);
    wr(12'h00, 3);
    repeat (15) @(negedge clk);
    wr(12'h00, 0);
    repeat (3) @(negedge clk);
    rd(12'h0C, d, e);
    chk("busy_abort", {31'd0, d[0]}, 0);
    repeat (40) @(negedge clk);
    chk_rd("result3_kept", 12'h4C, 0);
    chk_rd("done3_kept", 12'h10, 0);
    // Reset mid-scan restores reset values.
    per[0] = 4;
    wr(12'h08, 1);
    wr(12'h04, 50);
    wr(12'h00, 3);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) chk_rd($sformatf("rst_mid_%h", ra[i]), ra[i], rx[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
